// File: rtl/control_unit_if.sv
// control_unit_if: bundles the control unit's datapath-facing signals.
//   master (control unit): drives mux selects, load enables, opALU and MemWE;
//                          receives opcode (IR[7:0]) and zflag (ACC==0).
//   slave  (datapath):     the mirror image.
interface control_unit_if;
    logic [7:0] opcode;
    logic       zflag;
    logic       muxPC;
    logic       muxMAR;
    logic       muxACC;
    logic       loadPC;
    logic       loadMAR;
    logic       loadMDR;
    logic       loadIR;
    logic       loadACC;
    logic       opALU;
    logic       MemWE;

    modport master (
        input  opcode, zflag,
        output muxPC, muxMAR, muxACC, loadPC, loadMAR, loadMDR, loadIR, loadACC, opALU, MemWE
    );

    modport slave (
        output opcode, zflag,
        input  muxPC, muxMAR, muxACC, loadPC, loadMAR, loadMDR, loadIR, loadACC, opALU, MemWE
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 16-bit accumulator datapath.
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   run        in   1 = start the next instruction from FETCH1, 0 = hold (single-step)
//   bus        if   master side of control_unit_if (opcode/zflag in, controls + MemWE out)
//   halted     out  1 while in HALT
//   instr_done out  one-cycle pulse on the last cycle of each instruction
//   state      out  current state encoding (debug)
module control_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    control_unit_if.master bus,
    output logic           halted,
    output logic           instr_done,
    output logic [2:0]     state
);
    typedef enum logic [2:0] {
        FETCH1 = 3'd0,
        FETCH2 = 3'd1,
        FETCH3 = 3'd2,
        DECODE = 3'd3,
        EXMEM  = 3'd4,
        EXALU  = 3'd5,
        EXST   = 3'd6,
        HALT   = 3'd7
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_LAT - 1);
    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_OR     = 8'h02;
    localparam logic [7:0] OP_JUMP   = 8'h03;
    localparam logic [7:0] OP_JUMPZ  = 8'h04;
    localparam logic [7:0] OP_LOAD   = 8'h05;
    localparam logic [7:0] OP_STORE  = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    // ALU-class operation captured in DECODE so EXALU never looks at opcode: {ACC from MDR, ADD}
    logic [1:0] ex_q, ex_d;
    logic       wait_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH1;
            cnt_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
        end
    end

    assign wait_last = (cnt_q == WAIT_LAST);
    assign state     = state_q;

    // Every output is gated by rst_n so reset forces all strobes low immediately,
    // even in FETCH1 where loadMAR would otherwise follow run.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        ex_d        = ex_q;
        bus.muxPC   = 1'b0;
        bus.muxMAR  = 1'b0;
        bus.muxACC  = 1'b0;
        bus.loadPC  = 1'b0;
        bus.loadMAR = 1'b0;
        bus.loadMDR = 1'b0;
        bus.loadIR  = 1'b0;
        bus.loadACC = 1'b0;
        bus.opALU   = 1'b0;
        bus.MemWE   = 1'b0;
        halted      = 1'b0;
        instr_done  = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                FETCH1: begin
                    if (run) begin
                        bus.loadMAR = 1'b1;
                        state_d     = FETCH2;
                    end
                end
                FETCH2, EXMEM: begin
                    // counter is zero on entry because every other state clears it
                    bus.loadMDR = wait_last;
                    cnt_d       = wait_last ? 4'd0 : cnt_q + 4'd1;
                    if (wait_last) state_d = (state_q == FETCH2) ? FETCH3 : EXALU;
                end
                FETCH3: begin
                    bus.loadIR = 1'b1;
                    bus.loadPC = 1'b1;
                    state_d    = DECODE;
                end
                DECODE: begin
                    case (bus.opcode)
                        OP_ADD, OP_OR, OP_LOAD: begin
                            bus.loadMAR = 1'b1;
                            bus.muxMAR  = 1'b1;
                            ex_d        = {bus.opcode == OP_LOAD, bus.opcode == OP_ADD};
                            state_d     = EXMEM;
                        end
                        OP_STORE: begin
                            bus.loadMAR = 1'b1;
                            bus.muxMAR  = 1'b1;
                            state_d     = EXST;
                        end
                        OP_JUMP: begin
                            bus.loadPC = 1'b1;
                            bus.muxPC  = 1'b1;
                            instr_done = 1'b1;
                            state_d    = FETCH1;
                        end
                        OP_JUMPZ: begin
                            bus.loadPC = bus.zflag;
                            bus.muxPC  = bus.zflag;
                            instr_done = 1'b1;
                            state_d    = FETCH1;
                        end
                        OP_HALT: state_d = HALT;
                        default: begin
                            instr_done = 1'b1;
                            state_d    = FETCH1;
                        end
                    endcase
                end
                EXALU: begin
                    bus.loadACC = 1'b1;
                    bus.muxACC  = ex_q[1];
                    bus.opALU   = ex_q[0];
                    instr_done  = 1'b1;
                    state_d     = FETCH1;
                end
                EXST: begin
                    bus.MemWE  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH1;
                end
                HALT: halted = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives control_unit with a behavioural datapath and checks it against an
// instruction-level model (architectural PC/ACC/memory, per-opcode latency from MEM_LAT).
module tb_control_unit;
    logic       clk = 1'b0;
    logic       rst_n, run, run3;
    logic       halted, instr_done, halted3, instr_done3;
    logic [2:0] state, state3;
    int         n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    control_unit_if ifc ();
    control_unit_if ifc3 ();

    control_unit #(.MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .bus(ifc.master),
        .halted(halted), .instr_done(instr_done), .state(state)
    );

    control_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .run(run3), .bus(ifc3.master),
        .halted(halted3), .instr_done(instr_done3), .state(state3)
    );

    // datapath around dut (MEM_LAT=1)
    logic [15:0] img [256];
    logic [15:0] mem [256];
    logic [15:0] mdr, ir, acc;
    logic [7:0]  pc, mar;

    assign ifc.opcode = ir[7:0];
    assign ifc.zflag  = (acc == 16'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0; mar <= '0; mdr <= '0; ir <= '0; acc <= '0;
            mem <= img;
        end else begin
            if (ifc.loadPC)  pc  <= ifc.muxPC ? ir[15:8] : pc + 8'd1;
            if (ifc.loadMAR) mar <= ifc.muxMAR ? ir[15:8] : pc;
            if (ifc.loadMDR) mdr <= mem[mar];
            if (ifc.loadIR)  ir  <= mdr;
            if (ifc.loadACC) acc <= ifc.muxACC ? mdr : (ifc.opALU ? acc + mdr : acc | mdr);
            if (ifc.MemWE)   mem[mar] <= acc;
        end
    end

    function automatic logic [9:0] ctl1();
        return {ifc.muxPC, ifc.muxMAR, ifc.muxACC, ifc.loadPC, ifc.loadMAR,
                ifc.loadMDR, ifc.loadIR, ifc.loadACC, ifc.opALU, ifc.MemWE};
    endfunction

    function automatic logic [9:0] ctl3();
        return {ifc3.muxPC, ifc3.muxMAR, ifc3.muxACC, ifc3.loadPC, ifc3.loadMAR,
                ifc3.loadMDR, ifc3.loadIR, ifc3.loadACC, ifc3.opALU, ifc3.MemWE};
    endfunction

    // instruction-level reference state
    logic [15:0] ref_mem [256];
    logic [7:0]  rpc;
    logic [15:0] racc;
    bit          rhalt, desync;

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ref_mem = img;
        rpc    = 8'h00;
        racc   = 16'h0000;
        rhalt  = 1'b0;
        desync = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Execute one instruction in the model, then watch the DUT run it. Called #1 after a posedge.
    task automatic step();
        logic [15:0] w, exp_d, we_d;
        logic [7:0]  op, a, we_a;
        int          lat, cyc, we_n;
        bit          exp_we, got_done, got_halt;
        w = ref_mem[rpc]; op = w[7:0]; a = w[15:8];
        rpc = rpc + 8'd1; exp_we = 1'b0; exp_d = racc;
        case (op)
            8'h01:   begin racc = racc + ref_mem[a]; lat = 6; end
            8'h02:   begin racc = racc | ref_mem[a]; lat = 6; end
            8'h03:   begin rpc = a; lat = 4; end
            8'h04:   begin if (racc == 16'd0) rpc = a; lat = 4; end
            8'h05:   begin racc = ref_mem[a]; lat = 6; end
            8'h06:   begin ref_mem[a] = racc; exp_we = 1'b1; lat = 5; end
            8'hFF:   begin rhalt = 1'b1; lat = 5; end
            default: lat = 4;
        endcase
        cyc = 0; we_n = 0; got_done = 1'b0; got_halt = 1'b0; we_a = '0; we_d = '0;
        while (!got_done && !got_halt && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ifc.MemWE) begin we_n++; we_a = mar; we_d = acc; end
            got_done = instr_done;
            got_halt = halted;
        end
        n_vec++;
        if ({got_done, got_halt} !== {!rhalt, rhalt}) begin
            n_err++; desync = 1'b1;
            $display("FAIL end_kind op=%h: got done/halt=%b%b want %b%b", op, got_done, got_halt, !rhalt, rhalt);
        end
        n_vec++;
        if (cyc !== lat) begin
            n_err++; desync = 1'b1;
            $display("FAIL latency op=%h: got %0d want %0d", op, cyc, lat);
        end
        n_vec++;
        if (we_n !== int'(exp_we)) begin
            n_err++;
            $display("FAIL memwe_count op=%h: got %0d want %0d", op, we_n, int'(exp_we));
        end
        if (exp_we && we_n == 1) begin
            n_vec++;
            if ({we_a, we_d} !== {a, exp_d}) begin
                n_err++;
                $display("FAIL store_bus: got addr=%h data=%h want addr=%h data=%h", we_a, we_d, a, exp_d);
            end
        end
        if (!rhalt) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({pc, acc} !== {rpc, racc}) begin
                n_err++;
                $display("FAIL arch op=%h: got pc=%h acc=%h want pc=%h acc=%h", op, pc, acc, rpc, racc);
            end
        end
    endtask

    task automatic test_reset();
        clear_img();
        run = 1'b1; run3 = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({ctl1(), halted, instr_done, state} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {ctl1(), halted, instr_done, state});
        end
        n_vec++;
        if ({ctl3(), halted3, instr_done3, state3} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs_l3: got %h want 0", {ctl3(), halted3, instr_done3, state3});
        end
        run3 = 1'b0;
    endtask

    task automatic test_spec_program();
        clear_img();
        img[8'h00] = 16'h1005;
        img[8'h01] = 16'h1101;
        img[8'h10] = 16'h1234;
        img[8'h11] = 16'h0001;
        run = 1'b1;
        do_reset();
        step();
        step();
        n_vec++;
        if (acc !== 16'h1235) begin
            n_err++;
            $display("FAIL spec_add_acc: got %h want 1235", acc);
        end
    endtask

    task automatic test_store();
        clear_img();
        img[8'h00] = 16'h3005;
        img[8'h01] = 16'h2006;
        img[8'h30] = 16'h00AA;
        do_reset();
        step();
        step();
        n_vec++;
        if (mem[8'h20] !== 16'h00AA) begin
            n_err++;
            $display("FAIL store_mem: got %h want 00aa", mem[8'h20]);
        end
    endtask

    task automatic test_jumpz();
        clear_img();
        img[8'h00] = 16'h3105;
        img[8'h01] = 16'h4004;
        img[8'h31] = 16'h0000;
        img[8'h40] = 16'h3205;
        img[8'h41] = 16'h5004;
        img[8'h32] = 16'h0001;
        do_reset();
        repeat (4) step();
        n_vec++;
        if (pc !== 8'h42) begin
            n_err++;
            $display("FAIL jumpz_not_taken_pc: got %h want 42", pc);
        end
    endtask

    task automatic test_run_low();
        int bad = 0;
        clear_img();
        img[8'h00] = 16'h0103;
        run = 1'b0;
        do_reset();
        repeat (10) begin
            @(negedge clk);
            if (state !== 3'd0 || ctl1() !== 10'd0 || instr_done !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0 || pc !== 8'h00) begin
            n_err++;
            $display("FAIL run_low_idle: got %0d busy cycles pc=%h want 0 busy pc=00", bad, pc);
        end
        run = 1'b1;
    endtask

    task automatic test_reset_in_store();
        int  n = 0;
        clear_img();
        img[8'h00] = 16'h3005;
        img[8'h01] = 16'h2006;
        img[8'h30] = 16'h00AA;
        do_reset();
        while (state !== 3'd6 && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (state !== 3'd6 || ifc.MemWE !== 1'b1) begin
            n_err++;
            $display("FAIL reach_exst: got state=%0d memwe=%b want state=6 memwe=1", state, ifc.MemWE);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ifc.MemWE, instr_done, state} !== 5'd0) begin
            n_err++;
            $display("FAIL async_reset_exst: got memwe=%b done=%b state=%0d want 0/0/0", ifc.MemWE, instr_done, state);
        end
    endtask

    task automatic test_mem_lat3();
        int mdr_mask = 0, done_cyc = -1, cyc = 0;
        ifc3.opcode = 8'h05;
        ifc3.zflag  = 1'b0;
        run = 1'b0;
        do_reset();
        run3 = 1'b1;
        while (done_cyc < 0 && cyc < 25) begin
            @(negedge clk);
            cyc++;
            if (ifc3.loadMDR) mdr_mask |= (1 << cyc);
            if (instr_done3) begin done_cyc = cyc; run3 = 1'b0; end
        end
        run3 = 1'b0;
        n_vec++;
        if (mdr_mask !== ((1 << 4) | (1 << 9))) begin
            n_err++;
            $display("FAIL lat3_loadmdr_cycles: got mask %h want %h", mdr_mask, (1 << 4) | (1 << 9));
        end
        n_vec++;
        if (done_cyc !== 10) begin
            n_err++;
            $display("FAIL lat3_latency: got %0d want 10", done_cyc);
        end
        run = 1'b1;
    endtask

    task automatic test_halt();
        int bad = 0;
        clear_img();
        img[8'h03] = 16'h00FF;
        img[8'h04] = 16'h0005;
        do_reset();
        repeat (4) step();
        repeat (20) begin
            @(negedge clk);
            if (halted !== 1'b1 || ctl1() !== 10'd0 || instr_done !== 1'b0 || state !== 3'd7) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL halt_hold: got %0d bad cycles want 0", bad);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({halted, state} !== 4'd0) begin
            n_err++;
            $display("FAIL halt_reset: got halted=%b state=%0d want 0/0", halted, state);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) begin
                int         r;
                logic [7:0] op;
                r  = $urandom_range(0, 39);
                op = r < 5  ? 8'h01 : r < 9  ? 8'h02 : r < 13 ? 8'h03 : r < 17 ? 8'h04 :
                     r < 23 ? 8'h05 : r < 29 ? 8'h06 : r < 34 ? 8'h00 : r < 39 ? 8'(r + 7) : 8'hFF;
                img[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : {8'($urandom), op};
            end
            run = 1'b1;
            do_reset();
            for (int k = 0; k < 40 && !rhalt && !desync; k++) step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        run = 1'b0; run3 = 1'b0; rst_n = 1'b0;
        ifc3.opcode = 8'h00; ifc3.zflag = 1'b0;
        clear_img();
        test_reset();
        test_spec_program();
        test_store();
        test_jumpz();
        test_run_low();
        test_reset_in_store();
        test_mem_lat3();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
